// File: rtl/flashmem_arbiter.sv
// Round-robin arbiter sharing one SPI flash word-read engine between NUM_REQ requesters.
// Optional one-entry last-word cache enabled by defining FLASHMEM_ARB_CACHE_EN.
module flashmem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [24*NUM_REQ-1:0]   req_addr,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [31:0]             req_rdata,
  output logic                    mem_valid,
  output logic [23:0]             mem_addr,
  input  logic                    mem_ready,
  input  logic [31:0]             mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, HIT, GAP} state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     last_q;
  logic [IDX_W-1:0]     g_q;
  logic                 mem_valid_q;
  logic [23:0]          mem_addr_q;
  logic [NUM_REQ-1:0]   req_ready_q;
  logic [31:0]          req_rdata_q;

  logic                 found_d;
  logic [IDX_W-1:0]     gnt_d;
  logic [23:0]          gnt_addr_d;
  logic                 g_vld;
  logic [NUM_REQ-1:0]   g_onehot;
  logic                 hit_d;
  logic [31:0]          cdata_q;

  // Scan last+1, last+2, ... modulo NUM_REQ and take the first pending requester.
  always_comb begin
    found_d = 1'b0;
    gnt_d   = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found_d && req_valid[i] && (i == (int'(last_q) + k) % NUM_REQ)) begin
          found_d = 1'b1;
          gnt_d   = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    gnt_addr_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == gnt_d) gnt_addr_d = req_addr[24*i +: 24];
    end
  end

  always_comb begin
    g_vld    = 1'b0;
    g_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == g_q) begin
        g_vld       = req_valid[i];
        g_onehot[i] = 1'b1;
      end
    end
  end

`ifdef FLASHMEM_ARB_CACHE_EN
  logic [23:0] tag_q;
  logic        cvalid_q;

  assign hit_d = cvalid_q && (tag_q == gnt_addr_d);

  // Tag and data only matter once cvalid_q is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state_q == BUSY && mem_ready) begin
      tag_q   <= mem_addr_q;
      cdata_q <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                             cvalid_q <= 1'b0;
    else if (state_q == BUSY && mem_ready) cvalid_q <= 1'b1;
  end
`else
  assign hit_d   = 1'b0;
  assign cdata_q = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= IDX_W'(NUM_REQ - 1);
      g_q         <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      req_ready_q <= '0;
      req_rdata_q <= '0;
    end else begin
      req_ready_q <= '0;
      case (state_q)
        IDLE: begin
          if (found_d) begin
            g_q <= gnt_d;
            if (hit_d) begin
              state_q <= HIT;
            end else begin
              mem_addr_q  <= gnt_addr_d;
              mem_valid_q <= 1'b1;
              state_q     <= BUSY;
            end
          end
        end
        BUSY: begin
          // Completion takes priority over a same-cycle abort.
          if (mem_ready) begin
            req_rdata_q <= mem_rdata;
            req_ready_q <= g_onehot;
            mem_valid_q <= 1'b0;
            last_q      <= g_q;
            state_q     <= GAP;
          end else if (!g_vld) begin
            mem_valid_q <= 1'b0;
            state_q     <= GAP;
          end
        end
        HIT: begin
          req_rdata_q <= cdata_q;
          req_ready_q <= g_onehot;
          last_q      <= g_q;
          state_q     <= GAP;
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign req_rdata = req_rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_flashmem_arbiter.sv
// Directed bench for flashmem_arbiter: vector table of engine transactions plus
// hand-written abort, simultaneous-event, reset and cache sequences.
module tb_flashmem_arbiter;

  localparam int NUM_REQ = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [24*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]    req_ready;
  logic [31:0]           req_rdata;
  logic                  mem_valid;
  logic [23:0]           mem_addr;
  logic                  mem_ready;
  logic [31:0]           mem_rdata;

  int tests = 0;
  int fails = 0;
  int mon_err = 0;

  flashmem_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .req_rdata(req_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  vld;
    logic [23:0] a0;
    logic [23:0] a1;
    int          dly;
    logic [31:0] data;
    logic [23:0] eaddr;
    logic [1:0]  erdy;
    logic [1:0]  post;
  } vec_t;

  vec_t vt [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int cyc);
    cyc = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      cyc++;
      if (mem_valid) break;
    end
    if (!mem_valid) check("grant_timeout", 32'(mem_valid), 32'd1);
  endtask

  task automatic do_txn(input string tag, input vec_t v);
    int cyc;
    req_valid = v.vld;
    req_addr  = {v.a1, v.a0};
    wait_grant(cyc);
    check({tag, "_grant_lat"}, 32'(cyc), 32'd1);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'(v.eaddr));
    repeat (v.dly) step();
    check({tag, "_busy_hold"}, {7'd0, mem_valid, mem_addr}, {8'd1, v.eaddr});
    mem_ready = 1'b1;
    mem_rdata = v.data;
    step();
    mem_ready = 1'b0;
    mem_rdata = '0;
    check({tag, "_ready"}, 32'(req_ready), 32'(v.erdy));
    check({tag, "_rdata"}, req_rdata, v.data);
    check({tag, "_mv_drop"}, 32'(mem_valid), 32'd0);
    req_valid = v.post;
    step();
    check({tag, "_gap"}, {30'd0, req_ready}, 32'd0);
    check({tag, "_gap_mv"}, 32'(mem_valid), 32'd0);
  endtask

  // Continuous checks: ready one-hot, ready never alongside an open engine
  // transaction, and the engine address never changes while mem_valid stays high.
  logic        prev_mv = 1'b0;
  logic [23:0] prev_addr = '0;
  always @(negedge clk) begin
    if (!reset) begin
      if ($countones(req_ready) > 1) begin
        mon_err++;
        $display("FAIL onehot: req_ready=%b", req_ready);
      end
      if (req_ready != '0 && mem_valid) begin
        mon_err++;
        $display("FAIL gap: req_ready=%b with mem_valid=1", req_ready);
      end
      if (mem_valid && prev_mv && mem_addr != prev_addr) begin
        mon_err++;
        $display("FAIL addr_hold: mem_addr 0x%06h -> 0x%06h without gap", prev_addr, mem_addr);
      end
    end
    prev_mv   = mem_valid;
    prev_addr = mem_addr;
  end

  initial begin
    int cyc;
    vec_t v;

    vt[0] = '{vld: 2'b11, a0: 24'h000010, a1: 24'h000020, dly: 3,   data: 32'hA000_0010, eaddr: 24'h000010, erdy: 2'b01, post: 2'b11};
    vt[1] = '{vld: 2'b11, a0: 24'h000010, a1: 24'h000020, dly: 3,   data: 32'hB000_0020, eaddr: 24'h000020, erdy: 2'b10, post: 2'b11};
    vt[2] = '{vld: 2'b11, a0: 24'h000010, a1: 24'h000020, dly: 2,   data: 32'hA100_0010, eaddr: 24'h000010, erdy: 2'b01, post: 2'b11};
    vt[3] = '{vld: 2'b11, a0: 24'h000010, a1: 24'h000020, dly: 2,   data: 32'hB100_0020, eaddr: 24'h000020, erdy: 2'b10, post: 2'b00};
    vt[4] = '{vld: 2'b01, a0: 24'h100000, a1: 24'h000000, dly: 140, data: 32'hDEAD_BEEF, eaddr: 24'h100000, erdy: 2'b01, post: 2'b00};
    vt[5] = '{vld: 2'b10, a0: 24'h000000, a1: 24'h200000, dly: 5,   data: 32'hCAFE_F00D, eaddr: 24'h200000, erdy: 2'b10, post: 2'b00};

    reset = 1'b1; req_valid = '0; req_addr = '0; mem_ready = 1'b0; mem_rdata = '0;
    step(); step();
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_req_rdata", req_rdata, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) do_txn($sformatf("vec%0d", i), vt[i]);

    // Abort: requester 1 drops valid mid-transaction while requester 0 waits.
    req_valid = 2'b10; req_addr = {24'h000020, 24'h000010};
    wait_grant(cyc);
    check("abort_grant_addr", 32'(mem_addr), 32'h20);
    req_valid = 2'b11;
    repeat (50) step();
    req_valid = 2'b01;
    step();
    check("abort_mv_drop", 32'(mem_valid), 32'd0);
    check("abort_no_ready", 32'(req_ready), 32'd0);
    step();
    check("abort_gap_mv", 32'(mem_valid), 32'd0);
    step();
    check("abort_next_grant", {7'd0, mem_valid, mem_addr}, {8'd1, 24'h000010});
    mem_ready = 1'b1; mem_rdata = 32'h0000_AB0A;
    step();
    mem_ready = 1'b0; req_valid = 2'b00;
    check("abort_r0_ready", 32'(req_ready), 32'b01);
    check("abort_r0_rdata", req_rdata, 32'h0000_AB0A);
    step();

    // Completion and abort in the same cycle: completion wins.
    req_valid = 2'b10;
    wait_grant(cyc);
    repeat (2) step();
    mem_ready = 1'b1; mem_rdata = 32'h55AA_55AA; req_valid = 2'b00;
    step();
    mem_ready = 1'b0; mem_rdata = '0;
    check("simul_ready", 32'(req_ready), 32'b10);
    check("simul_rdata", req_rdata, 32'h55AA_55AA);
    step();
    check("simul_gap", 32'(req_ready), 32'd0);

    // Stray engine ready while idle is ignored.
    mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
    step();
    mem_ready = 1'b0; mem_rdata = '0;
    check("stray_ready", 32'(req_ready), 32'd0);
    check("stray_rdata", req_rdata, 32'h55AA_55AA);
    check("stray_mv", 32'(mem_valid), 32'd0);

    // Leave last pointing at requester 0, then reset mid-transaction of requester 1.
    v = '{vld: 2'b01, a0: 24'h000010, a1: 24'h000020, dly: 1, data: 32'h0BAD_F00D, eaddr: 24'h000010, erdy: 2'b01, post: 2'b00};
    do_txn("pre_rst", v);
    req_valid = 2'b10;
    wait_grant(cyc);
    check("rst_busy_addr", 32'(mem_addr), 32'h20);
    repeat (3) step();
    reset = 1'b1; req_valid = 2'b11;
    step();
    check("rst_busy_mv", 32'(mem_valid), 32'd0);
    check("rst_busy_ready", 32'(req_ready), 32'd0);
    check("rst_busy_rdata", req_rdata, 32'd0);
    reset = 1'b0;
    step();
    check("rst_r0_wins", {7'd0, mem_valid, mem_addr}, {8'd1, 24'h000010});
    mem_ready = 1'b1; mem_rdata = 32'h0F0F_0F0F;
    step();
    mem_ready = 1'b0; req_valid = 2'b00;
    check("rst_r0_ready", 32'(req_ready), 32'b01);
    step();

`ifdef FLASHMEM_ARB_CACHE_EN
    v = '{vld: 2'b01, a0: 24'h000400, a1: 24'h0, dly: 4, data: 32'h1234_5678, eaddr: 24'h000400, erdy: 2'b01, post: 2'b00};
    do_txn("cache_fill", v);
    req_valid = 2'b01; req_addr = {24'h0, 24'h000400};
    step();
    check("cache_hit_no_mv", 32'(mem_valid), 32'd0);
    check("cache_hit_wait", 32'(req_ready), 32'd0);
    step();
    check("cache_hit_ready", 32'(req_ready), 32'b01);
    check("cache_hit_rdata", req_rdata, 32'h1234_5678);
    check("cache_hit_mv", 32'(mem_valid), 32'd0);
    req_valid = 2'b00;
    step();
    check("cache_hit_gap", 32'(req_ready), 32'd0);
    v = '{vld: 2'b01, a0: 24'h000404, a1: 24'h0, dly: 3, data: 32'h9ABC_DEF0, eaddr: 24'h000404, erdy: 2'b01, post: 2'b00};
    do_txn("cache_miss", v);
`else
    v = '{vld: 2'b01, a0: 24'h000400, a1: 24'h0, dly: 4, data: 32'h1234_5678, eaddr: 24'h000400, erdy: 2'b01, post: 2'b00};
    do_txn("nocache_1", v);
    v.data = 32'h1357_9BDF;
    do_txn("nocache_2", v);
`endif

    repeat (2) step();
    check("monitor", 32'(mon_err), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/flashmem_arbiter.md
Name: flashmem_arbiter

Overview:
- Shares one SPI flash word-read engine (24-bit byte address in, 32-bit little-endian word out, valid/ready handshake) between NUM_REQ requesters.
- Typical requesters are the ROM loader, the PPU CHR fetch path and the debug/soft-CPU port.
- Arbitration is round-robin. The block sequences the engine one transaction at a time, routes the returned word and the ready pulse to the granted requester, and handles aborts cleanly.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- IDX_W, 3: width of the grant index register. Must satisfy 2**IDX_W >= NUM_REQ.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request. Held high, with its address stable, until that requester's ready pulse.
- req_addr  in  24*NUM_REQ  flattened byte addresses; requester i occupies bits [24*i+23:24*i].
- req_ready  out  NUM_REQ  one-cycle, one-hot completion pulse.
- req_rdata  out  32  returned word; valid in the req_ready cycle and held until the next completion.
- mem_valid  out  1  request to the flash engine.
- mem_addr  out  24  address to the flash engine.
- mem_ready  in  1  engine completion pulse (one cycle).
- mem_rdata  in  32  engine data; valid when mem_ready=1.

Behaviour:
- Reset values:
  - mem_valid=0, mem_addr=0, req_ready=0, req_rdata=0.
  - State = IDLE.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 wins the first tie.
- Reset mid-transaction drops mem_valid the next cycle. The engine de-selects itself on !valid, and no req_ready pulse is issued.
- All outputs are registered.
- IDLE:
  - If any req_valid is set, grant the first set bit scanning last+1, last+2, … modulo NUM_REQ.
  - Latch grant index g and req_addr[g]; set mem_valid=1 and mem_addr=latched address; go to BUSY.
  - If no req_valid is set, stay in IDLE.
- BUSY:
  - mem_valid and mem_addr are held constant.
  - If mem_ready=1: req_rdata<=mem_rdata, req_ready[g]<=1, mem_valid<=0, last<=g, go to GAP.
  - Else if req_valid[g]=0 (abort): mem_valid<=0, go to GAP, no ready pulse, last unchanged.
  - mem_ready and abort in the same cycle: completion wins and ready is pulsed.
- GAP:
  - One cycle with mem_valid=0. This guarantees chip-select deassertion between transactions.
  - req_ready returns to 0. Go to IDLE.
  - Arbitration restarts in IDLE the following cycle.
- Latency (no cache hit):
  - req_valid sampled in IDLE at edge E0 → mem_valid high after E0.
  - mem_ready sampled at edge Ek → req_ready high after Ek (one cycle after the engine's ready).
- Back-to-back requests: a requester that keeps req_valid high after its ready pulse is treated as a new request. It competes in round-robin, so with another requester pending, the other requester wins.
- Requests from non-granted requesters are ignored until IDLE; their valid stays pending.
- Address changes on the granted port during BUSY are ignored, because the address is latched.
- mem_ready outside BUSY is ignored.
- req_ready is never asserted on more than one bit.

Optional Feature:
- Macro: FLASHMEM_ARB_CACHE_EN.
- When defined:
  - Adds a one-entry last-word cache: 24-bit tag, 32-bit data, valid bit. Valid is cleared on reset.
  - On every completion: tag<=latched address, data<=mem_rdata, valid<=1.
  - In IDLE, if the granted address equals the tag and valid=1:
    - No engine access; mem_valid stays 0.
    - Next cycle: req_rdata<=cached data, req_ready[g]<=1, last<=g.
    - Then GAP, then IDLE.
  - An aborted transaction does not update the cache.
- When undefined: no cache registers; every grant issues an engine transaction.

Test Plan:
- Single request: req_valid=01, addr0=0x100000; engine model returns 0xDEADBEEF after 140 cycles. Expect mem_addr=0x100000, req_ready=01 exactly one cycle after mem_ready, req_rdata=0xDEADBEEF.
- Fairness: req_valid=11 held continuously, addr0=0x000010, addr1=0x000020. Expect mem_addr sequence 0x10, 0x20, 0x10, 0x20, and req_ready alternating 01, 10, 01, 10.
- Abort: requester 1 drops valid 50 cycles into BUSY. Expect mem_valid=0 the next cycle, no req_ready, one GAP cycle, and a pending requester 0 granted next.
- Simultaneous events: mem_ready=1 in the same cycle req_valid[g] falls. Expect req_ready[g] pulsed with the data. Reset asserted in BUSY: expect mem_valid=0 and req_ready=0 next cycle, and requester 0 wins after reset.
- Cache (FLASHMEM_ARB_CACHE_EN): read 0x000400 (returns 0x12345678), then read 0x000400 again. Second read: mem_valid never rises, req_ready two cycles after request, data 0x12345678. A read of 0x000404 goes to the engine.
- Gap check: across all tests, assert mem_valid is low for at least one cycle between consecutive engine transactions and that req_ready is one-hot or zero.
